// File: rtl/manhattan_pattern_detector.sv
// manhattan_pattern_detector
//
// Serial pattern detector with a run-time loadable pattern of 2..MAX_LEN
// bits, selectable overlapping / non-overlapping detection and a saturating
// match counter.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   sequence_in  : serial data bit, sampled only when in_valid=1
//   in_valid     : qualifies sequence_in
//   cfg_load     : one-cycle strobe loading cfg_pattern / cfg_len
//   cfg_pattern  : pattern, bit [cfg_len-1] is the first bit received
//   cfg_len      : pattern length in bits
//   overlap      : 1 = overlapping detection, 0 = non-overlapping
//   count_clr    : synchronous clear of match_count
//   detector_out : registered one-cycle match pulse
//   match_count  : saturating match count
//   armed        : a valid configuration is loaded
//   cfg_err      : one-cycle pulse when a cfg_load is rejected
//
// State  | meaning
// UNCFG  | no valid pattern loaded, valid bits ignored
// FILL   | configured, fewer than len bits collected since load/match
// RUN    | configured, at least len bits collected

module manhattan_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [4:0]         cfg_len,
    input  logic               overlap,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        UNCFG = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10
    } state_t;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t             state_q,   state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [4:0]         len_q,     len_d;
    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [4:0]         fill_q,    fill_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               det_q,     det_d;
    logic               err_q,     err_d;
    logic               armed_q,   armed_d;

    logic               cfg_ok;
    logic               cfg_accept;
    logic               match;
    logic               hit;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [4:0]         fill_inc;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        match      = 1'b0;

        cfg_ok     = (cfg_len >= 5'd2) && (cfg_len <= LEN_MAX);
        cfg_accept = cfg_load && cfg_ok;

        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
        fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 5'd1;
        hit        = ((hist_shift ^ pattern_q) & len_mask) == '0;

        case (state_q)
            UNCFG: begin
                state_d = UNCFG;
            end
            FILL, RUN: begin
                // An accepted load in the same cycle wins and drops the bit.
                if (in_valid && !cfg_accept) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    if (fill_inc == len_q && hit) begin
                        match = 1'b1;
                        if (overlap) begin
                            state_d = RUN;
                        end else begin
                            // Restart collection so bits of this match are not reused.
                            fill_d  = 5'd0;
                            state_d = FILL;
                        end
                    end else begin
                        state_d = (fill_inc == len_q) ? RUN : FILL;
                    end
                end
            end
            default: begin
                state_d = UNCFG;
            end
        endcase

        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                hist_d    = '0;
                fill_d    = 5'd0;
                state_d   = FILL;
            end else begin
                err_d = 1'b1;
            end
        end

        if (count_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        det_d   = match;
        armed_d = (state_d != UNCFG);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            det_q     <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = cnt_q;
    assign armed        = armed_q;
    assign cfg_err      = err_q;

endmodule

// File: doc/manhattan_pattern_detector.md
MANHATTAN_PATTERN_DETECTOR -- requirements
Module: manhattan_pattern_detector

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the longest detectable pattern in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sequence_in, input, 1: serial data bit.
REQ-006 Port in_valid, input, 1: sequence_in is sampled only when in_valid=1.
REQ-007 Port cfg_load, input, 1: one-cycle strobe that loads the new pattern configuration.
REQ-008 Port cfg_pattern, input, MAX_LEN: pattern; bit [cfg_len-1] is the first bit received and bit 0 is the last.
REQ-009 Port cfg_len, input, 5: pattern length in bits.
REQ-010 Port overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping; sampled each valid cycle.
REQ-011 Port count_clr, input, 1: synchronous clear of match_count.
REQ-012 Port detector_out, output, 1: registered one-cycle match pulse.
REQ-013 Port match_count, output, CNT_W: saturating count of matches.
REQ-014 Port armed, output, 1: high when a valid configuration is loaded.
REQ-015 Port cfg_err, output, 1: one-cycle pulse when cfg_load is rejected.

Function
REQ-016 The block SHALL implement three states:
- UNCFG: entered at reset; valid bits ignored; armed=0.
- FILL: configured; fewer than len bits in history.
- RUN: history holds at least len bits.
REQ-017 A cfg_load with 2 <= cfg_len <= MAX_LEN SHALL, at the next edge:
- latch pattern and len;
- clear history and the fill count;
- enter FILL.
REQ-018 A cfg_load with cfg_len < 2 or cfg_len > MAX_LEN SHALL pulse cfg_err for one cycle and leave state, pattern, len and history unchanged.
REQ-019 On each valid cycle in FILL or RUN, the block SHALL shift history left with sequence_in entering at bit 0, and increment the fill count, saturating at len.
REQ-020 The block SHALL declare a match when the updated fill count equals len and the updated history bits [len-1:0] equal pattern bits [len-1:0].
REQ-021 detector_out SHALL be 1 in exactly the cycle after the edge at which the matching bit was sampled (latency 1), and 0 otherwise.
REQ-022 On a match with overlap=1, the block SHALL keep history and remain in RUN.
REQ-023 On a match with overlap=0, the block SHALL zero the fill count and enter FILL, so that bits of the match are not reused.
REQ-024 Cycles with in_valid=0 SHALL hold history, fill count and state, and SHALL drive detector_out to 0.
REQ-025 match_count SHALL increment by 1 on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-026 When count_clr coincides with a match, match_count SHALL become 1; with count_clr alone it SHALL become 0.
REQ-027 When cfg_load coincides with in_valid, cfg_load SHALL take priority: the bit is dropped and no match is reported.
REQ-028 A rejected cfg_load SHALL NOT block the coincident valid bit, which is processed normally.
REQ-029 The next-state and match logic SHALL be fully assigned for every state value, with unused encodings returning to UNCFG.

Reset
REQ-030 While reset=1, the block SHALL hold state UNCFG with all of the following at 0: detector_out, match_count, armed, cfg_err, pattern, len, history and fill count.
REQ-031 Reset assertion SHALL act immediately, without waiting for a clock edge, including mid-pattern and mid-pulse.
REQ-032 After reset deasserts, the block SHALL require a new cfg_load before any detection.

Verification
REQ-033 The bench SHALL cover: load pattern 10110, len 5, overlap=1; stream 1011010110 valid every cycle -> detector_out pulses after bits 5 and 10; match_count=2.
REQ-034 The bench SHALL cover: pattern 1010, len 4; stream 1010101 with overlap=1 -> 2 pulses (after bits 4 and 6); the same stream with overlap=0 -> 1 pulse (after bit 4).
REQ-035 The bench SHALL cover: cfg_len=1 and cfg_len=MAX_LEN+1 -> cfg_err pulses once each, armed is unchanged, and the prior pattern still detects.
REQ-036 The bench SHALL cover: CNT_W=2 with 5 matches -> match_count sticks at 3; count_clr coincident with a match -> match_count=1.
REQ-037 The bench SHALL cover: in_valid gaps of random length inserted inside a matching stream -> pulses occur at the same valid-bit positions as the gap-free run.
REQ-038 The bench SHALL cover: reset asserted after 3 of 5 pattern bits -> outputs are 0 immediately and armed=0; after reconfiguration, only the full 5-bit pattern matches.
